// File: rtl/branch_sequencer.sv
// Multi-cycle branch resolver: latches a branch, decodes it, compares the
// operands, then reports the taken decision and target with a fixed latency.
module branch_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  opcode,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic [31:0] pc_plus4,
   input  logic [15:0] imm16,
   output logic        busy,
   output logic        done,
   output logic        pc_write,
   output logic [31:0] pc_next,
   output logic        taken,
   output logic [1:0]  branch_ctrl,
   output logic        illegal,
   output logic [15:0] taken_count
);

   typedef enum logic [1:0] {IDLE, LATCH, COMPARE, RESOLVE} state_t;

   state_t      state;
   logic [5:0]  op_q;
   logic [31:0] rs_q;
   logic [31:0] rt_q;
   logic [31:0] pc4_q;
   logic [15:0] imm_q;
   logic        ill_q;
   logic        eq_q;
   logic        gt_q;
   logic [31:0] target_q;
   logic        cond;
   logic        commit;

   always_comb begin
      cond = 1'b0;
      case (branch_ctrl)
         2'b00: cond = eq_q;
         2'b01: cond = ~eq_q;
         2'b10: cond = ~gt_q;
         2'b11: cond = gt_q;
         default: cond = 1'b0;
      endcase
      commit = cond & ~ill_q;
   end

   // Operands are captured once at acceptance so later input changes cannot
   // disturb the branch in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         pc_write    <= 1'b0;
         taken       <= 1'b0;
         illegal     <= 1'b0;
         pc_next     <= 32'h0;
         branch_ctrl <= 2'b00;
         taken_count <= 16'h0;
         op_q        <= 6'h0;
         rs_q        <= 32'h0;
         rt_q        <= 32'h0;
         pc4_q       <= 32'h0;
         imm_q       <= 16'h0;
         ill_q       <= 1'b0;
         eq_q        <= 1'b0;
         gt_q        <= 1'b0;
         target_q    <= 32'h0;
      end else begin
         done     <= 1'b0;
         pc_write <= 1'b0;
         taken    <= 1'b0;
         illegal  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= opcode;
                  rs_q  <= rs_val;
                  rt_q  <= rt_val;
                  pc4_q <= pc_plus4;
                  imm_q <= imm16;
                  busy  <= 1'b1;
                  state <= LATCH;
               end
            end
            LATCH: begin
               // Only 0x04-0x07 are branches; anything else keeps the old select.
               if (op_q[5:2] == 4'b0001) begin
                  branch_ctrl <= op_q[1:0];
                  ill_q       <= 1'b0;
               end else begin
                  ill_q       <= 1'b1;
               end
               state <= COMPARE;
            end
            COMPARE: begin
               eq_q     <= (rs_q == rt_q);
               gt_q     <= ($signed(rs_q) > $signed(rt_q));
               target_q <= pc4_q + {{14{imm_q[15]}}, imm_q, 2'b00};
               state    <= RESOLVE;
            end
            RESOLVE: begin
               done     <= 1'b1;
               busy     <= 1'b0;
               pc_next  <= target_q;
               taken    <= commit;
               pc_write <= commit;
               illegal  <= ill_q;
               if (commit && (taken_count != 16'hFFFF))
                  taken_count <= taken_count + 16'd1;
               state    <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized self-checking bench for branch_sequencer against a simple
// arithmetic reference of the branch rules.
module tb_branch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  opcode;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] pc_plus4;
   logic [15:0] imm16;
   logic        busy;
   logic        done;
   logic        pc_write;
   logic [31:0] pc_next;
   logic        taken;
   logic [1:0]  branch_ctrl;
   logic        illegal;
   logic [15:0] taken_count;

   int          checks = 0;
   int          errors = 0;
   logic [1:0]  exp_ctrl;
   logic [15:0] exp_count;
   logic [31:0] exp_pc;
   bit          pc_known;

   branch_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode),
      .rs_val(rs_val), .rt_val(rt_val), .pc_plus4(pc_plus4), .imm16(imm16),
      .busy(busy), .done(done), .pc_write(pc_write), .pc_next(pc_next),
      .taken(taken), .branch_ctrl(branch_ctrl), .illegal(illegal),
      .taken_count(taken_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void modelBranch(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                       input logic [31:0] pc4, input logic [15:0] imm,
                                       output bit legal, output bit tk, output logic [31:0] tgt);
      int signed a;
      int signed b;
      a = rs;
      b = rt;
      legal = (op >= 6'd4) && (op <= 6'd7);
      case (op)
         6'd4: tk = (rs == rt);
         6'd5: tk = (rs != rt);
         6'd6: tk = (a <= b);
         6'd7: tk = (a > b);
         default: tk = 1'b0;
      endcase
      tgt = pc4 + 32'(int'($signed(imm)) * 4);
   endfunction

   task automatic scrambleInputs();
      rs_val   = $urandom;
      rt_val   = $urandom;
      pc_plus4 = $urandom;
      imm16    = 16'($urandom);
      opcode   = 6'($urandom);
   endtask

   // Drives one branch and checks every cycle up to and including done.
   task automatic applyStimulus(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] pc4, input logic [15:0] imm, input bit hold);
      bit          legal;
      bit          tk;
      logic [31:0] tgt;
      modelBranch(op, rs, rt, pc4, imm, legal, tk, tgt);
      @(negedge clk);
      opcode = op; rs_val = rs; rt_val = rt; pc_plus4 = pc4; imm16 = imm; start = 1'b1;
      @(posedge clk); #1;
      checkOutput("busy_after_accept", busy, 1'b1);
      for (int c = 0; c < 3; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         checkOutput("done_early", done, 1'b0);
         checkOutput("pc_write_early", pc_write, 1'b0);
         if (pc_known) checkOutput("pc_next_hold", pc_next, exp_pc);
         @(negedge clk);
         scrambleInputs();
      end
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      if (legal) begin
         case (op)
            6'd4: exp_ctrl = 2'd0;
            6'd5: exp_ctrl = 2'd1;
            6'd6: exp_ctrl = 2'd2;
            default: exp_ctrl = 2'd3;
         endcase
      end
      if (legal && tk && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
      checkOutput("done", done, 1'b1);
      checkOutput("busy_at_done", busy, 1'b0);
      checkOutput("taken", taken, tk && legal);
      checkOutput("pc_write", pc_write, tk && legal);
      checkOutput("illegal", illegal, !legal);
      checkOutput("branch_ctrl", branch_ctrl, exp_ctrl);
      checkOutput("taken_count", taken_count, exp_count);
      if (legal) checkOutput("pc_next", pc_next, tgt);
      exp_pc   = tgt;
      pc_known = legal;
   endtask

   initial begin
      logic [5:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      reset = 1'b1; start = 1'b0;
      opcode = 6'h0; rs_val = 32'h0; rt_val = 32'h0; pc_plus4 = 32'h0; imm16 = 16'h0;
      exp_ctrl = 2'b00; exp_count = 16'h0; exp_pc = 32'h0; pc_known = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_pc_write", pc_write, 1'b0);
      checkOutput("rst_taken", taken, 1'b0);
      checkOutput("rst_illegal", illegal, 1'b0);
      checkOutput("rst_pc_next", pc_next, 32'h0);
      checkOutput("rst_branch_ctrl", branch_ctrl, 2'b00);
      checkOutput("rst_taken_count", taken_count, 16'h0);
      reset = 1'b0;

      applyStimulus(6'h04, 32'd5, 32'd5, 32'h100, 16'h0003, 1'b0);
      checkOutput("beq_target_const", pc_next, 32'h10C);
      checkOutput("beq_count_const", taken_count, 16'd1);
      applyStimulus(6'h07, 32'hFFFF_FFFF, 32'd1, 32'h200, 16'h0010, 1'b0);
      checkOutput("bgt_ctrl_const", branch_ctrl, 2'b11);
      applyStimulus(6'h06, 32'hFFFF_FFFF, 32'd1, 32'h200, 16'h0010, 1'b0);
      applyStimulus(6'h05, 32'd9, 32'd9, 32'h10, 16'hFFFC, 1'b0);
      checkOutput("bne_zero_const", pc_next, 32'h0);
      applyStimulus(6'h05, 32'd9, 32'd9, 32'h10, 16'hFFF8, 1'b0);
      checkOutput("bne_wrap_const", pc_next, 32'hFFFF_FFF0);
      applyStimulus(6'h08, 32'd3, 32'd3, 32'h80, 16'h0004, 1'b0);

      for (int i = 0; i < 30; i++) begin
         op = ($urandom_range(0, 9) < 8) ? 6'(4 + $urandom_range(0, 3)) : 6'($urandom_range(0, 63));
         if (op >= 6'd4 && op <= 6'd7 && i % 10 == 9) op = op + 6'd8;
         rs = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 6)) - 32'd3 : $urandom;
         rt = ($urandom_range(0, 2) == 0) ? rs : 32'($urandom_range(0, 6)) - 32'd3;
         applyStimulus(op, rs, rt, $urandom, 16'($urandom), 1'b0);
      end

      // start held high: each resolution follows the previous with no gap
      for (int i = 0; i < 8; i++) begin
         op = 6'(4 + $urandom_range(0, 3));
         rs = $urandom;
         rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
         applyStimulus(op, rs, rt, $urandom, 16'($urandom), 1'b1);
      end
      start = 1'b0;

      // jump the counter near saturation, then run two taken branches
      @(negedge clk);
      force dut.taken_count = 16'hFFFE;
      @(negedge clk);
      release dut.taken_count;
      exp_count = 16'hFFFE;
      applyStimulus(6'h04, 32'd1, 32'd1, 32'h400, 16'h0001, 1'b0);
      checkOutput("sat_first_const", taken_count, 16'hFFFF);
      applyStimulus(6'h07, 32'd2, 32'd1, 32'h400, 16'h0001, 1'b0);
      checkOutput("sat_hold_const", taken_count, 16'hFFFF);

      @(negedge clk);
      opcode = 6'h04; rs_val = 32'd1; rt_val = 32'd1; pc_plus4 = 32'h40; imm16 = 16'h1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", busy, 1'b0);
      checkOutput("abort_done", done, 1'b0);
      checkOutput("abort_pc_write", pc_write, 1'b0);
      checkOutput("abort_pc_next", pc_next, 32'h0);
      checkOutput("abort_branch_ctrl", branch_ctrl, 2'b00);
      checkOutput("abort_taken_count", taken_count, 16'h0);
      exp_count = 16'h0; exp_ctrl = 2'b00; exp_pc = 32'h0; pc_known = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         checkOutput("no_done_after_abort", {pc_write, done}, 2'b00);
      end
      applyStimulus(6'h06, 32'd4, 32'd8, 32'h1000, 16'h8000, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
